result_quantizer: RTL and testbench

Drains the 16-entry, 32-bit result buffer of the core after a matmul pass. It requantizes each accumulated value to signed 8 bits using a rounding arithmetic shift with saturation. It then streams the bytes out over a valid/ready interface toward the router. The block snapshots the buffer on `start`, so the core may begin its next pass while the drain is in progress.

---
 rtl/nnoc_pkg.sv | 19 +
 rtl/quant_sat.sv | 39 +++
 rtl/result_quantizer.sv | 145 ++++++++++++++
 tb/tb_result_quantizer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nnoc_pkg.sv
// Shared types and constants for the result drain path of the core.
package nnoc_pkg;

   localparam int ACC_WIDTH = 32;
   localparam int Q_WIDTH   = 8;
   localparam int BUF_DEPTH = 16;

   typedef logic signed [ACC_WIDTH-1:0] acc_t;
   typedef logic signed [Q_WIDTH-1:0]   q8_t;

   localparam int Q_MAX = 127;
   localparam int Q_MIN = -128;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } drain_state_t;

endpackage

// File: rtl/quant_sat.sv
// Requantizer: rounding arithmetic right shift (half toward +inf) followed
// by saturation to the signed output range. Purely combinational.
module quant_sat
   import nnoc_pkg::*;
#(
   parameter int ACCUMULATE = ACC_WIDTH,
   parameter int OUT_WIDTH  = Q_WIDTH
) (
   input  logic [ACCUMULATE-1:0] x,
   input  logic [4:0]            shift,
   output logic [OUT_WIDTH-1:0]  y
);

   // One extra bit keeps x + rounding bias from overflowing for large positives.
   localparam logic signed [ACCUMULATE:0] SAT_HI = $signed((ACCUMULATE+1)'(Q_MAX));
   localparam logic signed [ACCUMULATE:0] SAT_LO = $signed((ACCUMULATE+1)'(Q_MIN));

   logic signed [ACCUMULATE:0] x_ext;
   logic signed [ACCUMULATE:0] round_bias;
   logic signed [ACCUMULATE:0] shifted;

   // Add half an output LSB, shift arithmetically, then clamp.
   always_comb begin
      x_ext      = $signed({x[ACCUMULATE-1], x});
      round_bias = '0;
      if (shift != 5'd0) begin
         round_bias = $signed((ACCUMULATE+1)'(1) << (shift - 5'd1));
      end
      shifted = (x_ext + round_bias) >>> shift;
      if (shifted > SAT_HI) begin
         y = SAT_HI[OUT_WIDTH-1:0];
      end else if (shifted < SAT_LO) begin
         y = SAT_LO[OUT_WIDTH-1:0];
      end else begin
         y = shifted[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/result_quantizer.sv
// Snapshots the core result buffer on start, then streams the requantized
// bytes one per handshake over valid/ready, flagging the last beat and
// pulsing done once the final beat has been accepted.
module result_quantizer
   import nnoc_pkg::*;
#(
   parameter int ACCUMULATE = ACC_WIDTH,
   parameter int OUT_WIDTH  = Q_WIDTH,
   parameter int DEPTH      = BUF_DEPTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [4:0]                  shift,
   input  logic [ACCUMULATE-1:0]       result_buffer [DEPTH],
   output logic [OUT_WIDTH-1:0]        out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic [$clog2(DEPTH)-1:0]    out_index,
   output logic                        busy,
   output logic                        done
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   drain_state_t           state_reg, state_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic [OUT_WIDTH-1:0]   out_data_reg, out_data_next;
   logic [IDX_W-1:0]       out_index_reg, out_index_next;
   logic                   out_valid_reg, out_valid_next;
   logic                   out_last_reg, out_last_next;
   logic                   done_reg, done_next;
   logic [4:0]             shift_q_reg, shift_q_next;
   logic                   snap_we;

   logic [ACCUMULATE-1:0]  snapshot [DEPTH];

   logic [ACCUMULATE-1:0]  q_x;
   logic [4:0]             q_shift;
   logic [OUT_WIDTH-1:0]   q_y;

   // In IDLE the first beat comes straight from the live buffer so it can be
   // presented the cycle after start; afterwards it reads the frozen copy.
   assign q_x     = (state_reg == IDLE) ? result_buffer[0] : snapshot[idx_reg];
   assign q_shift = (state_reg == IDLE) ? shift : shift_q_reg;

   quant_sat #(
      .ACCUMULATE (ACCUMULATE),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_quant (
      .x     (q_x),
      .shift (q_shift),
      .y     (q_y)
   );

   // Snapshot capture; contents are irrelevant until the next accepted start.
   always_ff @(posedge clk) begin
      if (snap_we) begin
         for (int i = 0; i < DEPTH; i++) begin
            snapshot[i] <= result_buffer[i];
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         out_data_reg  <= '0;
         out_index_reg <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         done_reg      <= 1'b0;
         shift_q_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         out_data_reg  <= out_data_next;
         out_index_reg <= out_index_next;
         out_valid_reg <= out_valid_next;
         out_last_reg  <= out_last_next;
         done_reg      <= done_next;
         shift_q_reg   <= shift_q_next;
      end
   end

   // Next-state and output logic; everything holds unless a transition fires.
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      out_data_next  = out_data_reg;
      out_index_next = out_index_reg;
      out_valid_next = out_valid_reg;
      out_last_next  = out_last_reg;
      done_next      = 1'b0;
      shift_q_next   = shift_q_reg;
      snap_we        = 1'b0;

      case (state_reg)
         IDLE: begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            if (start) begin
               snap_we        = 1'b1;
               shift_q_next   = shift;
               out_data_next  = q_y;
               out_valid_next = 1'b1;
               out_index_next = '0;
               out_last_next  = (LAST_IDX == '0);
               idx_next       = IDX_W'(1);
               state_next     = SEND;
            end
         end
         SEND: begin
            if (out_valid_reg && out_ready) begin
               if (out_last_reg) begin
                  out_valid_next = 1'b0;
                  out_last_next  = 1'b0;
                  done_next      = 1'b1;
                  state_next     = IDLE;
               end else begin
                  out_data_next  = q_y;
                  out_index_next = idx_reg;
                  out_last_next  = (idx_reg == LAST_IDX);
                  idx_next       = idx_reg + IDX_W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;
   assign out_index = out_index_reg;
   assign busy      = (state_reg == SEND);
   assign done      = done_reg;

endmodule

// File: tb/tb_result_quantizer.sv
// Directed bench for result_quantizer: fixed vectors with hand-derived bytes,
// backpressure, snapshot isolation, mid-stream reset and back-to-back passes.
module tb_result_quantizer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  shift;
   logic [31:0] rb [16];
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [3:0]  out_index;
   logic        busy;
   logic        done;

   logic [7:0]  exp_q [16];
   int          checks;
   int          errors;

   result_quantizer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .shift         (shift),
      .result_buffer (rb),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .out_index     (out_index),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_data"},  32'(out_data),  32'd0);
      check({tag, "_index"}, 32'(out_index), 32'd0);
      check({tag, "_last"},  32'(out_last),  32'd0);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_done"},  32'(done),      32'd0);
   endtask

   // Called at the sample point right after the accepting edge. Walks the
   // stream, optionally stalling one beat and pulsing start mid-pass, and
   // returns at the sample point where done should be high.
   task automatic expect_stream(input string tag, input int stall_at, input int stall_len,
                                input int pulse_at);
      int beat;
      int cyc;
      int stalls;
      beat   = 0;
      cyc    = 0;
      stalls = 0;
      while (beat < 16 && cyc < 100) begin
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_index"}, 32'(out_index), 32'(beat));
         check({tag, "_data"},  32'(out_data),  32'(exp_q[beat]));
         check({tag, "_last"},  32'(out_last),  32'(beat == 15));
         check({tag, "_busy"},  32'(busy),      32'd1);
         check({tag, "_done"},  32'(done),      32'd0);
         start = (beat == pulse_at);
         if (beat == stall_at && stalls < stall_len) begin
            out_ready = 1'b0;
            stalls++;
         end else begin
            out_ready = 1'b1;
            beat++;
         end
         step();
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      $display("pass %s: %0d beats in %0d cycles", tag, beat, cyc);
      check({tag, "_beats"},    32'(beat),      32'd16);
      check({tag, "_cycles"},   32'(cyc),       32'(16 + stall_len));
      check({tag, "_done_hi"},  32'(done),      32'd1);
      check({tag, "_end_vld"},  32'(out_valid), 32'd0);
      check({tag, "_end_busy"}, 32'(busy),      32'd0);
      check({tag, "_end_last"}, 32'(out_last),  32'd0);
   endtask

   task automatic load_pass1();
      rb[0] = 32'h0000_1280; exp_q[0] = 8'h13;
      rb[1] = 32'h0001_0000; exp_q[1] = 8'h7F;
      rb[2] = 32'hFFFF_8000; exp_q[2] = 8'h80;
      rb[3] = 32'hFFFE_0000; exp_q[3] = 8'h80;
      rb[4] = 32'hFFFF_FF80; exp_q[4] = 8'h00;
      // k*256 + 128 is exactly half an LSB above k, so it rounds up to k+1.
      for (int k = 5; k < 15; k++) begin
         rb[k]    = 32'(k * 256 + 128);
         exp_q[k] = 8'(k + 1);
      end
      // -3.5 in output LSBs rounds toward +inf to -3.
      rb[15] = 32'hFFFF_FC80; exp_q[15] = 8'hFD;
      shift = 5'd8;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b0;
      start     = 1'b0;
      shift     = 5'd0;
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         rb[k]    = '0;
         exp_q[k] = '0;
      end

      // Reset state.
      step();
      step();
      check_quiet("rst");
      #1 reset = 1'b1;
      step();
      check("idle_valid", 32'(out_valid), 32'd0);

      // Pass 1: shift 8, rounding and saturation vectors, ready always high.
      load_pass1();
      start = 1'b1;
      step();
      start = 1'b0;
      expect_stream("p1", -1, 0, -1);
      step();
      check("p1_done_pulse", 32'(done), 32'd0);

      // Pass 2: shift 0 pass-through, with a 3-cycle stall on beat 5.
      for (int k = 0; k < 16; k++) begin
         rb[k]    = 32'(k);
         exp_q[k] = 8'(k);
      end
      shift = 5'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      expect_stream("p2", 5, 3, -1);

      // Start in the done cycle: the next pass follows with a 1-cycle gap.
      for (int k = 0; k < 16; k++) begin
         rb[k]    = 32'(k * 16 + 8);
         exp_q[k] = 8'(k + 1);
      end
      shift = 5'd4;
      start = 1'b1;
      step();
      start = 1'b0;
      expect_stream("p2b", -1, 0, -1);
      step();
      check("p2b_done_pulse", 32'(done), 32'd0);

      // Snapshot isolation: buffer and shift change after the accepting edge,
      // and a start pulse on beat 7 must be ignored.
      rb[0] = 32'h0000_0200; exp_q[0] = 8'h7F;
      for (int k = 1; k < 15; k++) begin
         rb[k]    = 32'(0 - k);
         exp_q[k] = 8'(256 - k);
      end
      rb[15] = 32'hFFFF_FE00; exp_q[15] = 8'h80;
      shift = 5'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         rb[k] = 32'h1234_5678;
      end
      shift = 5'd4;
      expect_stream("snap", -1, 0, 7);
      for (int i = 0; i < 3; i++) begin
         step();
         check("snap_no_restart", 32'(out_valid), 32'd0);
         check("snap_idle_busy",  32'(busy),      32'd0);
      end

      // Reset asserted while beat 9 is on the bus.
      load_pass1();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int b = 0; b < 9; b++) begin
         check("rst_pre_index", 32'(out_index), 32'(b));
         step();
      end
      check("rst_pre_b9_index", 32'(out_index), 32'd9);
      check("rst_pre_b9_data",  32'(out_data),  32'(exp_q[9]));
      #1 reset = 1'b0;
      #1;
      check_quiet("rst_async");
      step();
      #1 reset = 1'b1;
      step();
      check("rst_after_valid", 32'(out_valid), 32'd0);
      check("rst_after_busy",  32'(busy),      32'd0);

      // Fresh pass after reset, shift 31 at the extremes of the input range.
      for (int k = 0; k < 16; k++) begin
         if (k % 2 == 0) begin
            rb[k]    = 32'h7FFF_FFFF;
            exp_q[k] = 8'h01;
         end else begin
            rb[k]    = 32'h8000_0000;
            exp_q[k] = 8'hFF;
         end
      end
      shift = 5'd31;
      start = 1'b1;
      step();
      start = 1'b0;
      expect_stream("p4", -1, 0, -1);
      step();
      check("p4_done_pulse", 32'(done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
